// File: rtl/master_cmd_queue_if.sv
// Host-frame input, issue bus and status signals of the master command queue.
// The slave modport is the queue itself; the master modport is its environment.
interface master_cmd_queue_if #(
    parameter int unsigned DEPTH = 4
);
    localparam int unsigned LW = $clog2(DEPTH + 1);

    logic          HOST_WE;
    logic          HOST_SOF;
    logic [31:0]   HOST_DATA;
    logic [47:0]   TIME_NOW;
    logic          CMD_DONE;
    logic          WR_DATA;
    logic [47:0]   MEM_DDS_freq;
    logic [47:0]   MEM_DDS_delta_freq;
    logic [31:0]   MEM_DDS_delta_rate;
    logic [47:0]   MEM_TIME_START;
    logic [15:0]   MEM_N_impuls;
    logic [1:0]    MEM_TYPE_impulse;
    logic [31:0]   MEM_Interval_Ti;
    logic [31:0]   MEM_Interval_Tp;
    logic [31:0]   MEM_Tblank1;
    logic [31:0]   MEM_Tblank2;
    logic [LW-1:0] LEVEL;
    logic          FULL;
    logic          EMPTY;
    logic          ERR_FRAME;
    logic          ERR_OVF;
    logic          ERR_STALE;

    modport slave (
        input  HOST_WE, HOST_SOF, HOST_DATA, TIME_NOW, CMD_DONE,
        output WR_DATA, MEM_DDS_freq, MEM_DDS_delta_freq, MEM_DDS_delta_rate,
               MEM_TIME_START, MEM_N_impuls, MEM_TYPE_impulse, MEM_Interval_Ti,
               MEM_Interval_Tp, MEM_Tblank1, MEM_Tblank2, LEVEL, FULL, EMPTY,
               ERR_FRAME, ERR_OVF, ERR_STALE
    );

    modport master (
        output HOST_WE, HOST_SOF, HOST_DATA, TIME_NOW, CMD_DONE,
        input  WR_DATA, MEM_DDS_freq, MEM_DDS_delta_freq, MEM_DDS_delta_rate,
               MEM_TIME_START, MEM_N_impuls, MEM_TYPE_impulse, MEM_Interval_Ti,
               MEM_Interval_Tp, MEM_Tblank1, MEM_Tblank2, LEVEL, FULL, EMPTY,
               ERR_FRAME, ERR_OVF, ERR_STALE
    );
endinterface

// File: rtl/master_cmd_queue.sv
// Assembles 11-word host frames into pulse-train commands, buffers them, drops stale
// ones and issues one command at a time to MASTER_START.
module master_cmd_queue #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned GUARD = 16
) (
    input  logic                 CLK,
    input  logic                 RESET,
    master_cmd_queue_if.slave    bus
);
    localparam int unsigned LW = $clog2(DEPTH + 1);
    localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    typedef struct packed {
        logic [47:0] freq;
        logic [47:0] dfreq;
        logic [31:0] rate;
        logic [47:0] tstart;
        logic [15:0] n;
        logic [1:0]  typ;
        logic [31:0] ti;
        logic [31:0] tp;
        logic [31:0] tb1;
        logic [31:0] tb2;
    } cmd_t;

    typedef enum logic { A_IDLE, A_COLL } asm_state_t;
    typedef enum logic { S_IDLE, S_BUSY } iss_state_t;

    asm_state_t    r_astate, w_astate_nxt;
    iss_state_t    r_sstate, w_sstate_nxt;
    logic [3:0]    r_cnt, w_cnt_nxt;
    logic          w_store, w_frame_err, w_frame_done;
    logic [3:0]    w_idx;
    cmd_t          r_asm;
    logic          r_push;

    cmd_t          r_mem [DEPTH];
    logic [PW-1:0] r_wr_ptr, r_rd_ptr;
    logic [LW-1:0] r_level, w_level_nxt;
    logic          r_full, r_empty;
    logic          w_push_ok, w_ovf, w_pop, w_issue, w_drop, w_stale;
    cmd_t          w_head;

    cmd_t          r_cmd;
    logic          r_wr, r_err_frame, r_err_ovf, r_err_stale;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
    endfunction

    // Assembler: word sequencing and frame-error detection
    always_comb begin
        w_astate_nxt = r_astate;
        w_cnt_nxt    = r_cnt;
        w_store      = 1'b0;
        w_idx        = 4'd0;
        w_frame_err  = 1'b0;
        w_frame_done = 1'b0;
        case (r_astate)
            A_IDLE: if (bus.HOST_WE && bus.HOST_SOF) begin
                w_store      = 1'b1;
                w_cnt_nxt    = 4'd1;
                w_astate_nxt = A_COLL;
            end
            A_COLL: if (bus.HOST_WE) begin
                w_store = 1'b1;
                if (bus.HOST_SOF) begin
                    w_frame_err = 1'b1;
                    w_cnt_nxt   = 4'd1;
                end else begin
                    w_idx     = r_cnt;
                    w_cnt_nxt = r_cnt + 4'd1;
                    if (r_cnt == 4'd10) begin
                        w_frame_done = 1'b1;
                        w_cnt_nxt    = 4'd0;
                        w_astate_nxt = A_IDLE;
                    end
                end
            end
            default: w_astate_nxt = A_IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            r_astate <= A_IDLE;
            r_cnt    <= 4'd0;
        end else begin
            r_astate <= w_astate_nxt;
            r_cnt    <= w_cnt_nxt;
        end
    end

    // Field unpacking; the record is pushed the cycle after word 10 lands, so a new
    // frame may start overwriting r_asm in that same cycle.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            r_asm  <= '0;
            r_push <= 1'b0;
        end else begin
            r_push <= w_frame_done;
            if (w_store) begin
                case (w_idx)
                    4'd0:  r_asm.freq[31:0] <= bus.HOST_DATA;
                    4'd1:  begin
                        r_asm.freq[47:32] <= bus.HOST_DATA[15:0];
                        r_asm.dfreq[15:0] <= bus.HOST_DATA[31:16];
                    end
                    4'd2:  r_asm.dfreq[47:16] <= bus.HOST_DATA;
                    4'd3:  r_asm.rate <= bus.HOST_DATA;
                    4'd4:  r_asm.tstart[31:0] <= bus.HOST_DATA;
                    4'd5:  begin
                        r_asm.tstart[47:32] <= bus.HOST_DATA[15:0];
                        r_asm.n             <= bus.HOST_DATA[31:16];
                    end
                    4'd6:  r_asm.typ <= bus.HOST_DATA[1:0];
                    4'd7:  r_asm.ti  <= bus.HOST_DATA;
                    4'd8:  r_asm.tp  <= bus.HOST_DATA;
                    4'd9:  r_asm.tb1 <= bus.HOST_DATA;
                    4'd10: r_asm.tb2 <= bus.HOST_DATA;
                    default: ;
                endcase
            end
        end
    end

    // FIFO bookkeeping; a pop frees a slot for a push in the same cycle
    assign w_push_ok = r_push && (!r_full || w_pop);
    assign w_ovf     = r_push && !w_push_ok;
    assign w_head    = r_mem[r_rd_ptr];

    always_comb begin
        w_level_nxt = r_level;
        if (w_push_ok && !w_pop)
            w_level_nxt = r_level + LW'(1);
        else if (!w_push_ok && w_pop)
            w_level_nxt = r_level - LW'(1);
    end

    always_ff @(posedge CLK) begin
        if (w_push_ok)
            r_mem[r_wr_ptr] <= r_asm;
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_level  <= '0;
            r_full   <= 1'b0;
            r_empty  <= 1'b1;
        end else begin
            if (w_push_ok)
                r_wr_ptr <= ptr_inc(r_wr_ptr);
            if (w_pop)
                r_rd_ptr <= ptr_inc(r_rd_ptr);
            r_level <= w_level_nxt;
            r_full  <= (w_level_nxt == LW'(DEPTH));
            r_empty <= (w_level_nxt == '0);
        end
    end

    // Issue FSM: the 49-bit sum keeps TIME_NOW+GUARD from wrapping past zero
    assign w_stale = {1'b0, w_head.tstart} < ({1'b0, bus.TIME_NOW} + 49'(GUARD));

    always_comb begin
        w_sstate_nxt = r_sstate;
        w_pop        = 1'b0;
        w_issue      = 1'b0;
        w_drop       = 1'b0;
        case (r_sstate)
            S_IDLE: if (!r_empty) begin
                w_pop = 1'b1;
                if (w_stale) begin
                    w_drop = 1'b1;
                end else begin
                    w_issue      = 1'b1;
                    w_sstate_nxt = S_BUSY;
                end
            end
            S_BUSY: if (bus.CMD_DONE) w_sstate_nxt = S_IDLE;
            default: w_sstate_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            r_sstate    <= S_IDLE;
            r_cmd       <= '0;
            r_wr        <= 1'b0;
            r_err_frame <= 1'b0;
            r_err_ovf   <= 1'b0;
            r_err_stale <= 1'b0;
        end else begin
            r_sstate    <= w_sstate_nxt;
            r_wr        <= w_issue;
            r_err_frame <= w_frame_err;
            r_err_ovf   <= w_ovf;
            r_err_stale <= w_drop;
            if (w_issue)
                r_cmd <= w_head;
        end
    end

    assign bus.WR_DATA            = r_wr;
    assign bus.MEM_DDS_freq       = r_cmd.freq;
    assign bus.MEM_DDS_delta_freq = r_cmd.dfreq;
    assign bus.MEM_DDS_delta_rate = r_cmd.rate;
    assign bus.MEM_TIME_START     = r_cmd.tstart;
    assign bus.MEM_N_impuls       = r_cmd.n;
    assign bus.MEM_TYPE_impulse   = r_cmd.typ;
    assign bus.MEM_Interval_Ti    = r_cmd.ti;
    assign bus.MEM_Interval_Tp    = r_cmd.tp;
    assign bus.MEM_Tblank1        = r_cmd.tb1;
    assign bus.MEM_Tblank2        = r_cmd.tb2;
    assign bus.LEVEL              = r_level;
    assign bus.FULL               = r_full;
    assign bus.EMPTY              = r_empty;
    assign bus.ERR_FRAME          = r_err_frame;
    assign bus.ERR_OVF            = r_err_ovf;
    assign bus.ERR_STALE          = r_err_stale;
endmodule

// File: tb/tb_master_cmd_queue.sv
// Scoreboard bench for master_cmd_queue: a queue-level reference model predicts every
// issue and error pulse; a negedge monitor pops and compares against the DUT.
module tb_master_cmd_queue;
    localparam int unsigned DEPTH = 4;
    localparam int unsigned GUARD = 16;

    typedef struct packed {
        logic [47:0] freq;
        logic [47:0] dfreq;
        logic [31:0] rate;
        logic [47:0] tstart;
        logic [15:0] n;
        logic [1:0]  typ;
        logic [31:0] ti;
        logic [31:0] tp;
        logic [31:0] tb1;
        logic [31:0] tb2;
    } cmd_t;

    typedef struct {
        int   cyc;
        cmd_t rec;
    } iss_t;

    logic CLK = 1'b0;
    logic RESET = 1'b1;
    always #5 CLK = ~CLK;

    master_cmd_queue_if #(.DEPTH(DEPTH)) bus ();
    master_cmd_queue #(.DEPTH(DEPTH), .GUARD(GUARD)) dut (.CLK(CLK), .RESET(RESET), .bus(bus));

    int errors = 0, checks = 0, cyc = 0;
    int n_wr = 0, n_ferr = 0, n_ovf = 0, n_stale = 0;
    bit auto_done = 0, done_force = 0;
    int tstep = 0;

    iss_t q_wr[$];
    int   q_ferr[$], q_oerr[$], q_serr[$];

    // Reference model state
    cmd_t        m_q[$];
    logic [31:0] m_words [11];
    int          m_cnt = 0;
    bit          m_coll = 0, m_pend = 0, m_busy = 0;
    cmd_t        m_pend_rec, m_mem;
    int          m_level = 0;

    function automatic cmd_t decode(input logic [31:0] w [11]);
        cmd_t c;
        c.freq   = {w[1][15:0], w[0]};
        c.dfreq  = {w[2], w[1][31:16]};
        c.rate   = w[3];
        c.tstart = {w[5][15:0], w[4]};
        c.n      = w[5][31:16];
        c.typ    = w[6][1:0];
        c.ti     = w[7];
        c.tp     = w[8];
        c.tb1    = w[9];
        c.tb2    = w[10];
        return c;
    endfunction

    function automatic cmd_t get_mem();
        cmd_t c;
        c = {bus.MEM_DDS_freq, bus.MEM_DDS_delta_freq, bus.MEM_DDS_delta_rate, bus.MEM_TIME_START,
             bus.MEM_N_impuls, bus.MEM_TYPE_impulse, bus.MEM_Interval_Ti, bus.MEM_Interval_Tp,
             bus.MEM_Tblank1, bus.MEM_Tblank2};
        return c;
    endfunction

    function automatic cmd_t gen_cmd(input logic [47:0] ts);
        cmd_t c;
        c.freq   = {16'($urandom), $urandom};
        c.dfreq  = {16'($urandom), $urandom};
        c.rate   = $urandom;
        c.tstart = ts;
        c.n      = 16'($urandom);
        c.typ    = 2'($urandom);
        c.ti     = $urandom;
        c.tp     = $urandom;
        c.tb1    = $urandom;
        c.tb2    = $urandom;
        return c;
    endfunction

    // Model: one step per clock edge, from the inputs the DUT samples at that edge
    initial forever begin
        @(posedge CLK);
        cyc++;
        if (RESET) begin
            m_q.delete();
            m_coll = 0; m_cnt = 0; m_pend = 0; m_busy = 0; m_mem = '0;
        end else begin
            if (m_busy) begin
                if (bus.CMD_DONE) m_busy = 0;
            end else if (m_q.size() > 0) begin
                cmd_t h;
                h = m_q.pop_front();
                if ({1'b0, h.tstart} < {1'b0, bus.TIME_NOW} + 49'(GUARD)) begin
                    q_serr.push_back(cyc);
                end else begin
                    m_busy = 1;
                    m_mem  = h;
                    q_wr.push_back('{cyc, h});
                end
            end
            if (m_pend) begin
                if (m_q.size() < DEPTH) m_q.push_back(m_pend_rec);
                else q_oerr.push_back(cyc);
                m_pend = 0;
            end
            if (bus.HOST_WE) begin
                if (bus.HOST_SOF) begin
                    if (m_coll) q_ferr.push_back(cyc);
                    m_words[0] = bus.HOST_DATA;
                    m_cnt = 1; m_coll = 1;
                end else if (m_coll) begin
                    m_words[m_cnt] = bus.HOST_DATA;
                    m_cnt++;
                    if (m_cnt == 11) begin
                        m_pend_rec = decode(m_words);
                        m_pend = 1; m_coll = 0;
                    end
                end
            end
        end
        m_level = m_q.size();
    end

    task automatic chk_pulse(input string nm, input logic got, input bit has, input int fc,
                             output bit do_pop);
        do_pop = 0;
        if (got) begin
            checks++;
            if (!has || fc != cyc) begin
                errors++;
                $display("FAIL %s: pulse at cycle %0d, expected none (next expected %0d)", nm, cyc, has ? fc : -1);
            end else do_pop = 1;
        end else if (has && fc <= cyc) begin
            checks++; errors++;
            $display("FAIL %s: no pulse at cycle %0d, expected one", nm, fc);
            do_pop = 1;
        end
    endtask

    // Monitor
    initial forever begin
        bit p;
        @(negedge CLK);
        if (cyc == 0) continue;
        if (bus.WR_DATA) begin
            n_wr++;
            checks++;
            if (q_wr.size() == 0 || q_wr[0].cyc != cyc) begin
                errors++;
                $display("FAIL wr_data: strobe at cycle %0d, expected at %0d", cyc, q_wr.size() > 0 ? q_wr[0].cyc : -1);
            end else begin
                iss_t e;
                e = q_wr.pop_front();
                if (get_mem() !== e.rec) begin
                    errors++;
                    $display("FAIL wr_fields: got %h expected %h", get_mem(), e.rec);
                end
            end
        end else if (q_wr.size() > 0 && q_wr[0].cyc <= cyc) begin
            checks++; errors++;
            $display("FAIL wr_data: no strobe at cycle %0d, expected one", q_wr[0].cyc);
            void'(q_wr.pop_front());
        end
        if (bus.ERR_FRAME) n_ferr++;
        if (bus.ERR_OVF) n_ovf++;
        if (bus.ERR_STALE) n_stale++;
        chk_pulse("err_frame", bus.ERR_FRAME, q_ferr.size() > 0, q_ferr.size() > 0 ? q_ferr[0] : 0, p);
        if (p) void'(q_ferr.pop_front());
        chk_pulse("err_ovf", bus.ERR_OVF, q_oerr.size() > 0, q_oerr.size() > 0 ? q_oerr[0] : 0, p);
        if (p) void'(q_oerr.pop_front());
        chk_pulse("err_stale", bus.ERR_STALE, q_serr.size() > 0, q_serr.size() > 0 ? q_serr[0] : 0, p);
        if (p) void'(q_serr.pop_front());
        checks++;
        if (int'(bus.LEVEL) != m_level || bus.FULL != (m_level == DEPTH) || bus.EMPTY != (m_level == 0)) begin
            errors++;
            $display("FAIL status: cycle %0d level/full/empty %0d/%b/%b expected %0d/%b/%b", cyc,
                     bus.LEVEL, bus.FULL, bus.EMPTY, m_level, m_level == DEPTH, m_level == 0);
        end
        checks++;
        if (get_mem() !== m_mem) begin
            errors++;
            $display("FAIL mem_hold: cycle %0d got %h expected %h", cyc, get_mem(), m_mem);
        end
    end

    task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, got, exp);
        end
    endtask

    task automatic put(input logic we, input logic sof, input logic [31:0] d);
        bus.HOST_WE   = we;
        bus.HOST_SOF  = sof;
        bus.HOST_DATA = d;
        bus.CMD_DONE  = done_force || (auto_done && ($urandom_range(0, 7) == 0));
        bus.TIME_NOW  = bus.TIME_NOW + 48'(tstep);
        @(negedge CLK);
    endtask

    task automatic put_done();
        done_force = 1;
        put(1'b0, 1'b0, 32'd0);
        done_force = 0;
    endtask

    // Sends words 0..nw-1 of a frame (optional random gaps), then one idle cycle
    task automatic send_frame(input cmd_t c, input bit gaps, input int nw, output int t_last);
        logic [31:0] w [11];
        w[0]  = c.freq[31:0];
        w[1]  = {c.dfreq[15:0], c.freq[47:32]};
        w[2]  = c.dfreq[47:16];
        w[3]  = c.rate;
        w[4]  = c.tstart[31:0];
        w[5]  = {c.n, c.tstart[47:32]};
        w[6]  = {30'($urandom), c.typ};
        w[7]  = c.ti;
        w[8]  = c.tp;
        w[9]  = c.tb1;
        w[10] = c.tb2;
        for (int i = 0; i < nw; i++) begin
            if (gaps && i > 0 && $urandom_range(0, 3) == 0) put(1'b0, 1'b0, $urandom);
            put(1'b1, i == 0, w[i]);
        end
        t_last = cyc;
        put(1'b0, 1'b0, 32'd0);
    endtask

    task automatic wait_wr(output int lat);
        lat = -1;
        for (int i = 0; i < 20; i++) begin
            if (bus.WR_DATA) begin
                lat = i;
                break;
            end
            put(1'b0, 1'b0, 32'd0);
        end
    endtask

    task automatic drain();
        for (int i = 0; i < 80 && (m_busy || m_q.size() > 0 || m_pend); i++) begin
            if (m_busy) put_done();
            else put(1'b0, 1'b0, 32'd0);
        end
        repeat (2) put(1'b0, 1'b0, 32'd0);
    endtask

    initial begin
        cmd_t c, r1;
        int t10, lat, b_wr, b_x;
        bus.HOST_WE = 0; bus.HOST_SOF = 0; bus.HOST_DATA = 0; bus.TIME_NOW = 0; bus.CMD_DONE = 0;
        RESET = 1;
        repeat (3) @(negedge CLK);
        chk("reset_wr", bus.WR_DATA, 0);
        chk("reset_level", bus.LEVEL, 0);
        chk("reset_empty", bus.EMPTY, 1);
        chk("reset_full", bus.FULL, 0);
        chk("reset_err", {bus.ERR_FRAME, bus.ERR_OVF, bus.ERR_STALE}, 0);
        chk("reset_tstart", bus.MEM_TIME_START, 0);
        RESET = 0;
        put(1'b0, 1'b0, 32'd0);

        // Single frame into an idle, empty queue
        r1 = gen_cmd(48'd1000);
        send_frame(r1, 0, 11, t10);
        wait_wr(lat);
        chk("t1_latency", 64'(cyc - t10), 2);
        checks++;
        if (get_mem() !== r1) begin
            errors++;
            $display("FAIL t1_fields: got %h expected %h", get_mem(), r1);
        end
        repeat (2) put(1'b0, 1'b0, 32'd0);
        chk("t1_level", bus.LEVEL, 0);
        drain();

        // Two frames queued behind a busy command
        b_wr = n_wr;
        send_frame(gen_cmd(48'd2000), 0, 11, t10);
        send_frame(gen_cmd(48'd2001), 0, 11, t10);
        send_frame(gen_cmd(48'd2002), 0, 11, t10);
        repeat (3) put(1'b0, 1'b0, 32'd0);
        chk("t2_level", bus.LEVEL, 2);
        chk("t2_issued", 64'(n_wr - b_wr), 1);
        put_done();
        chk("t2_wr_same", bus.WR_DATA, 0);
        put(1'b0, 1'b0, 32'd0);
        chk("t2_wr_next", bus.WR_DATA, 1);
        chk("t2_tstart", bus.MEM_TIME_START, 48'd2001);
        drain();

        // Overflow: DEPTH+1 frames while busy
        b_x = n_ovf;
        for (int f = 0; f < DEPTH + 2; f++) send_frame(gen_cmd(48'(3000 + f)), 0, 11, t10);
        repeat (3) put(1'b0, 1'b0, 32'd0);
        chk("t3_full", bus.FULL, 1);
        chk("t3_level", bus.LEVEL, DEPTH);
        chk("t3_ovf", 64'(n_ovf - b_x), 1);
        drain();

        // SOF at word 5 restarts the frame
        b_x = n_ferr;
        send_frame(gen_cmd(48'd4000), 0, 5, t10);
        c = gen_cmd(48'd4001);
        send_frame(c, 0, 11, t10);
        wait_wr(lat);
        chk("t4_ferr", 64'(n_ferr - b_x), 1);
        checks++;
        if (get_mem() !== c) begin
            errors++;
            $display("FAIL t4_fields: got %h expected %h", get_mem(), c);
        end
        drain();

        // Stale boundary at TIME_NOW+GUARD
        bus.TIME_NOW = 48'd5000;
        b_wr = n_wr; b_x = n_stale;
        send_frame(gen_cmd(48'(5000 + GUARD - 1)), 0, 11, t10);
        repeat (4) put(1'b0, 1'b0, 32'd0);
        chk("t5_stale", 64'(n_stale - b_x), 1);
        chk("t5_no_wr", 64'(n_wr - b_wr), 0);
        send_frame(gen_cmd(48'(5000 + GUARD)), 0, 11, t10);
        wait_wr(lat);
        chk("t5_issue_tstart", bus.MEM_TIME_START, 48'(5000 + GUARD));
        drain();

        // Reset mid-frame and while busy
        send_frame(gen_cmd(48'd9000), 0, 6, t10);
        RESET = 1;
        put(1'b1, 1'b0, 32'h3);
        put(1'b0, 1'b0, 32'd0);
        RESET = 0;
        chk("t6_level_a", bus.LEVEL, 0);
        send_frame(gen_cmd(48'd9100), 0, 11, t10);
        wait_wr(lat);
        put(1'b0, 1'b0, 32'd0);
        RESET = 1;
        repeat (2) put(1'b0, 1'b0, 32'd0);
        RESET = 0;
        chk("t6_wr", bus.WR_DATA, 0);
        chk("t6_tstart", bus.MEM_TIME_START, 0);
        chk("t6_empty", bus.EMPTY, 1);
        b_wr = n_wr;
        send_frame(gen_cmd(48'd9200), 0, 11, t10);
        wait_wr(lat);
        put(1'b0, 1'b0, 32'd0);
        chk("t6_reissue", 64'(n_wr - b_wr), 1);
        drain();

        // Randomized traffic with moving time and random CMD_DONE
        auto_done = 1; tstep = 1;
        for (int f = 0; f < 40; f++) begin
            if ($urandom_range(0, 7) == 0) put(1'b1, 1'b0, $urandom);
            c = gen_cmd(bus.TIME_NOW + 48'($urandom_range(0, 100)) - 48'd20);
            send_frame(c, 1, ($urandom_range(0, 9) == 0) ? $urandom_range(1, 10) : 11, t10);
        end
        repeat (100) put(1'b0, 1'b0, 32'd0);
        auto_done = 0;
        drain();
        chk("end_wr_queue", q_wr.size(), 0);
        chk("end_pulse_queues", q_ferr.size() + q_oerr.size() + q_serr.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #1000000;
        errors++;
        $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
